// File: rtl/tx_frame_map_pkg.sv
// Shared constants for the OFDM transmit frame assembler. The receiver channel-estimate
// reference uses the same training LFSR seed and taps.
package tx_frame_map_pkg;

  localparam int DW_DEF   = 12;
  localparam int NFFT_DEF = 512;
  localparam int NSYM_DEF = 7;
  localparam int GAP_DEF  = 10;
  localparam logic signed [11:0] TRAIN_AMP_DEF = 12'sd1024;

  // Training sequence generator: x^9 + x^5 + 1, Fibonacci form.
  localparam int LFSR_W = 9;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 9'h1FF;
  localparam int LFSR_TAP_HI = 8;
  localparam int LFSR_TAP_LO = 4;

  localparam int PILOT_SPACING = 64;
  localparam int PILOT_BITS    = $clog2(PILOT_SPACING);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TRAIN = 3'd1,
    ST_GAP_T = 3'd2,
    ST_DATA  = 3'd3,
    ST_GAP_D = 3'd4
  } state_e;

endpackage

// File: rtl/tx_train_lfsr.sv
// 9-bit training-symbol LFSR with synchronous load and step enable; sign_o is the
// current bit 0, which selects the BPSK polarity of the training sample.
module tx_train_lfsr
  import tx_frame_map_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic sign_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = LFSR_SEED;
    end else if (en_i) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_HI] ^ lfsr_q[LFSR_TAP_LO]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign sign_o = lfsr_q[0];

endmodule

// File: rtl/tx_frame_map.sv
// OFDM transmit frame assembler: one BPSK training symbol, then NSYM data symbols from the
// mapper, with GAP idle cycles after each symbol. Define TX_FRAME_PILOT_EN for pilot insertion.
module tx_frame_map
  import tx_frame_map_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int NFFT = NFFT_DEF,
  parameter int NSYM = NSYM_DEF,
  parameter int GAP  = GAP_DEF,
  parameter logic signed [DW-1:0] TRAIN_AMP = TRAIN_AMP_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] din_re,
  input  logic [DW-1:0] din_im,
  input  logic          din_vld,
  output logic          din_rdy,
  output logic [DW-1:0] dout_re,
  output logic [DW-1:0] dout_im,
  output logic          dout_vld,
  output logic          dout_sos,
  output logic          dout_train,
  output logic          busy,
  output logic          done
);

  localparam int SC_W  = $clog2(NFFT);
  localparam int SYM_W = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(NFFT - 1);
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(NSYM - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic signed [DW-1:0] NEG_AMP = -TRAIN_AMP;
  localparam state_e AFTER_TRAIN = (GAP > 0) ? ST_GAP_T : ST_DATA;
  localparam state_e AFTER_SYM   = (GAP > 0) ? ST_GAP_D : ST_DATA;
  localparam state_e AFTER_FRAME = (GAP > 0) ? ST_GAP_D : ST_IDLE;

  state_e state_q, state_d;
  logic [SC_W-1:0]  sc_q, sc_d;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             last_q, last_d;
  logic [DW-1:0]    re_q, re_d, im_q, im_d;
  logic             vld_q, vld_d, sos_q, sos_d, train_q, train_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             rdy;
  logic             pilot;
  logic             lfsr_load, lfsr_en, lfsr_sign;

  tx_train_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load_i (lfsr_load),
    .en_i   (lfsr_en),
    .sign_o (lfsr_sign)
  );

`ifdef TX_FRAME_PILOT_EN
  assign pilot = (state_q == ST_DATA) && (sc_q[PILOT_BITS-1:0] == '0);
`else
  assign pilot = 1'b0;
`endif

  // last_q marks that the final data symbol has been sent, so GAP_D knows to end the frame.
  always_comb begin
    state_d   = state_q;
    sc_d      = sc_q;
    sym_d     = sym_q;
    gap_d     = gap_q;
    last_d    = last_q;
    re_d      = '0;
    im_d      = '0;
    vld_d     = 1'b0;
    sos_d     = 1'b0;
    train_d   = 1'b0;
    done_d    = 1'b0;
    rdy       = 1'b0;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_TRAIN;
          sc_d      = '0;
          sym_d     = '0;
          gap_d     = '0;
          last_d    = 1'b0;
          lfsr_load = 1'b1;
        end
      end
      ST_TRAIN: begin
        vld_d   = 1'b1;
        sos_d   = (sc_q == '0);
        train_d = 1'b1;
        re_d    = lfsr_sign ? NEG_AMP : TRAIN_AMP;
        lfsr_en = 1'b1;
        sc_d    = sc_q + SC_W'(1);
        if (sc_q == SC_LAST) begin
          sc_d    = '0;
          state_d = AFTER_TRAIN;
        end
      end
      ST_GAP_T, ST_GAP_D: begin
        gap_d = gap_q + GAP_W'(1);
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = (state_q == ST_GAP_D && last_q) ? ST_IDLE : ST_DATA;
          if (state_q == ST_GAP_D && last_q) begin
            last_d = 1'b0;
          end
        end
      end
      ST_DATA: begin
        rdy = ~pilot;
        if (pilot || din_vld) begin
          vld_d = 1'b1;
          sos_d = (sc_q == '0);
          re_d  = pilot ? TRAIN_AMP : din_re;
          im_d  = pilot ? '0 : din_im;
          sc_d  = sc_q + SC_W'(1);
          if (sc_q == SC_LAST) begin
            sc_d = '0;
            if (sym_q == SYM_LAST) begin
              done_d  = 1'b1;
              sym_d   = '0;
              last_d  = 1'b1;
              state_d = AFTER_FRAME;
            end else begin
              sym_d   = sym_q + SYM_W'(1);
              state_d = AFTER_SYM;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sc_q    <= '0;
      sym_q   <= '0;
      gap_q   <= '0;
      last_q  <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
      vld_q   <= 1'b0;
      sos_q   <= 1'b0;
      train_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      sym_q   <= sym_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
      re_q    <= re_d;
      im_q    <= im_d;
      vld_q   <= vld_d;
      sos_q   <= sos_d;
      train_q <= train_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign din_rdy    = rdy & ~rst;
  assign dout_re    = re_q;
  assign dout_im    = im_q;
  assign dout_vld   = vld_q;
  assign dout_sos   = sos_q;
  assign dout_train = train_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_tx_frame_map.sv
// Directed bench for tx_frame_map: nominal frame with ignored restart, stalled ramp input,
// mid-frame reset abort and a fresh frame afterwards.
module tb_tx_frame_map;

  localparam int DW      = 12;
  localparam int NFFT    = 512;
  localparam int NSYM    = 7;
  localparam int GAP     = 10;
  localparam int TOTAL   = NFFT * (NSYM + 1);
  localparam int AMP     = 1024;
  localparam int BUDGET  = 4 * TOTAL;
`ifdef TX_FRAME_PILOT_EN
  localparam bit PILOTS  = 1'b1;
`else
  localparam bit PILOTS  = 1'b0;
`endif
  localparam int CONSUME = PILOTS ? NSYM * (NFFT - NFFT / 64) : NSYM * NFFT;

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] dinRe;
  logic [DW-1:0] dinIm;
  logic          dinVld;
  logic          dinRdy;
  logic [DW-1:0] doutRe;
  logic [DW-1:0] doutIm;
  logic          doutVld;
  logic          doutSos;
  logic          doutTrain;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  tx_frame_map #(
    .DW        (DW),
    .NFFT      (NFFT),
    .NSYM      (NSYM),
    .GAP       (GAP),
    .TRAIN_AMP (12'sd1024)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .din_re     (dinRe),
    .din_im     (dinIm),
    .din_vld    (dinVld),
    .din_rdy    (dinRdy),
    .dout_re    (doutRe),
    .dout_im    (doutIm),
    .dout_vld   (doutVld),
    .dout_sos   (doutSos),
    .dout_train (doutTrain),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the design wedges somewhere no bounded loop covers.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected frame completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [DW-1:0] rampRe(input int i);
    return DW'(i % 2048);
  endfunction

  function automatic logic [DW-1:0] rampIm(input int i);
    return DW'(4095 - (i % 4096));
  endfunction

  function automatic logic [63:0] allOutputs();
    return 64'({doutRe, doutIm, doutVld, doutSos, doutTrain, dinRdy, busy, done});
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit vld, input int idx);
    dinVld = vld;
    dinRe  = rampRe(idx);
    dinIm  = rampIm(idx);
  endtask

  // Runs one frame. restartAt >= 0 re-pulses start after that training sample;
  // abortAt >= 0 asserts rst after that data sample and returns.
  task automatic runFrame(input string name, input bit toggleVld, input int restartAt,
                          input int abortAt);
    int pos, n, expIdx, dataIdx, doneCnt, lastN, extraVld, k;
    bit vld, restarted, prevRdy;
    logic [8:0] m;
    logic [DW-1:0] eRe, eIm;
    pos = 0; n = 0; expIdx = 0; dataIdx = 0; doneCnt = 0; lastN = 0; extraVld = 0;
    vld = 1'b1; restarted = 1'b0; prevRdy = 1'b0; m = 9'h1FF;
    @(negedge clk);
    start = 1'b1;
    applyStimulus(vld, dataIdx);
    @(negedge clk);
    start = 1'b0;
    checkOutput($sformatf("%s busyAfterStart", name), 64'(busy), 64'(1));
    while (pos < TOTAL && n < BUDGET) begin
      start = 1'b0;
      if (doutVld) begin
        if (pos < NFFT) begin
          eRe = m[0] ? DW'(-AMP) : DW'(AMP);
          eIm = '0;
          m   = {m[7:0], m[8] ^ m[4]};
        end else if (PILOTS && ((pos - NFFT) % 64 == 0)) begin
          eRe = DW'(AMP);
          eIm = '0;
          checkOutput($sformatf("%s pilotRdy[%0d]", name, pos - NFFT), 64'(prevRdy), 64'(0));
        end else begin
          eRe = rampRe(expIdx);
          eIm = rampIm(expIdx);
          expIdx++;
        end
        if (pos == 0) begin
          checkOutput($sformatf("%s firstTrainRe", name), 64'(doutRe), 64'(12'hC00));
        end
        if (!toggleVld && (pos % NFFT == 0)) begin
          checkOutput($sformatf("%s sosTime[%0d]", name, pos), 64'(n),
                      64'(1 + pos + GAP * (pos / NFFT)));
        end
        checkOutput($sformatf("%s sample[%0d]", name, pos),
                    64'({doutRe, doutIm, doutSos, doutTrain, done}),
                    64'({eRe, eIm, (pos % NFFT == 0), (pos < NFFT), (pos == TOTAL - 1)}));
        pos++;
        lastN = n;
      end
      if (done) doneCnt++;
      if (restartAt >= 0 && !restarted && pos == restartAt + 1) begin
        checkOutput($sformatf("%s busyAtRestart", name), 64'(busy), 64'(1));
        start = 1'b1;
        restarted = 1'b1;
      end
      if (abortAt >= 0 && pos == NFFT + abortAt + 1) begin
        rst = 1'b1;
        @(negedge clk);
        checkOutput($sformatf("%s resetOutputs", name), allOutputs(), 64'(0));
        checkOutput($sformatf("%s noDoneOnAbort", name), 64'(doneCnt), 64'(0));
        rst = 1'b0;
        return;
      end
      if (toggleVld) vld = ~vld;
      applyStimulus(vld, dataIdx);
      prevRdy = dinRdy;
      if (vld && dinRdy) dataIdx++;
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("%s frameLen", name), 64'(pos), 64'(TOTAL));
    k = 0;
    while (busy && k < 100) begin
      if (doutVld) extraVld++;
      if (done) doneCnt++;
      applyStimulus(1'b1, dataIdx);
      if (dinRdy) dataIdx++;
      @(negedge clk);
      n++;
      k++;
    end
    checkOutput($sformatf("%s busyDrop", name), 64'(n), 64'(lastN + GAP));
    checkOutput($sformatf("%s trailingVld", name), 64'(extraVld), 64'(0));
    checkOutput($sformatf("%s doneCount", name), 64'(doneCnt), 64'(1));
    checkOutput($sformatf("%s consumed", name), 64'(dataIdx), 64'(CONSUME));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    applyStimulus(1'b1, 0);
    repeat (3) @(negedge clk);
    checkOutput("resetState", allOutputs(), 64'(0));
    start = 1'b1;
    @(negedge clk);
    checkOutput("rstWinsOverStart", 64'({busy, doutVld}), 64'(0));
    start = 1'b0;
    rst   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idleAfterRstStart", 64'({busy, doutVld, dinRdy}), 64'(0));

    runFrame("nominal", 1'b0, 100, -1);
    runFrame("ramp", 1'b1, -1, -1);
    runFrame("abort", 1'b0, -1, 1000);
    runFrame("afterAbort", 1'b0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_frame_map.md
Name: tx_frame_map

Overview:
- Transmit-side frame assembler for the OFDM chain; the counterpart of the receiver channel-estimate and compensation path.
- On a start pulse it emits one frame to the IFFT:
  - one BPSK training symbol of NFFT subcarriers, generated internally;
  - then NSYM data symbols of NFFT subcarriers, taken from the QAM mapper through a valid/ready handshake.
- Output order matches the receiver: a training block of 512 samples, then 7x512 = 3584 data samples.

Parameters:
- DW, 12, width of each re/im sample, two's complement.
- NFFT, 512, subcarriers per symbol; power of two.
- NSYM, 7, data symbols per frame.
- GAP, 10, idle cycles inserted after every symbol, including the training symbol; 0 is allowed.
- TRAIN_AMP, 12'sd1024, BPSK training amplitude on re.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle frame request; ignored unless in IDLE.
- din_re  in  DW  mapped data, real part.
- din_im  in  DW  mapped data, imaginary part.
- din_vld  in  1  data valid.
- din_rdy  out  1  block accepts data this cycle.
- dout_re  out  DW  frame sample, real part.
- dout_im  out  DW  frame sample, imaginary part.
- dout_vld  out  1  output sample valid.
- dout_sos  out  1  first subcarrier of a symbol, qualified by dout_vld.
- dout_train  out  1  current sample belongs to the training symbol.
- busy  out  1  frame in progress (state not IDLE).
- done  out  1  one-cycle pulse, coincident with the last data sample.

Behaviour:
- Clock and reset:
  - Single clock clk. rst is synchronous, active-high, and sampled on posedge clk.
  - Under reset every output is 0: dout_re, dout_im, dout_vld, dout_sos, dout_train, din_rdy, busy, done. State returns to IDLE, counters clear, LFSR is set to 9'h1FF.
- Counters:
  - sc_cnt is the subcarrier index, 0..NFFT-1, log2(NFFT) bits.
  - sym_cnt is 0..NSYM-1.
  - gap_cnt is 0..GAP-1.
- State machine:
  - IDLE: wait for start. start=1 -> TRAIN, with sc_cnt=0 and LFSR=9'h1FF.
  - TRAIN: emit one sample per cycle.
    - Sample value: re = LFSR[0] ? -TRAIN_AMP : +TRAIN_AMP, im = 0.
    - LFSR polynomial x^9+x^5+1, Fibonacci form: new bit = q[8]^q[4], shifted into bit 0.
    - At sc_cnt=NFFT-1 -> GAP_T, or -> DATA if GAP=0.
  - GAP_T / GAP_D: dout_vld=0 for exactly GAP cycles.
    - GAP_T -> DATA.
    - GAP_D -> DATA while symbols remain, otherwise -> IDLE.
  - DATA:
    - din_rdy=1 combinationally while in DATA (pilot exception below).
    - A transfer happens on din_vld&din_rdy. The sample is registered to dout with 1-cycle latency, and sc_cnt advances.
    - If din_vld=0, dout_vld=0 next cycle and all counters hold; stalls are allowed anywhere within a symbol.
    - Last subcarrier of a non-final symbol -> GAP_D (or the next DATA symbol if GAP=0), with sym_cnt+1.
    - Last subcarrier of the final symbol (sym_cnt=NSYM-1): done pulses with that output sample, then -> GAP_D (if GAP>0) -> IDLE.
- Output registers:
  - All outputs except din_rdy are registered.
  - dout_sos=1 with the sc_cnt=0 sample of every symbol.
  - dout_train=1 for all NFFT training samples.
- Latency: first training sample appears 2 cycles after the start cycle (state update, then output register).
- Boundary rules:
  - start while busy=1 is ignored.
  - start in the same cycle as rst: rst wins.
  - rst mid-frame: abort immediately and return to IDLE; no done pulse.
  - din_vld asserted outside DATA: not consumed, because din_rdy=0.
  - Throughput with no stalls: NFFT*(NSYM+1) + GAP*(NSYM+1) cycles per frame.

Optional Feature:
- Macro: TX_FRAME_PILOT_EN.
- Defined:
  - In DATA, subcarriers with sc_cnt[5:0]==0 (every 64th, 8 per symbol at NFFT=512) carry pilot re=+TRAIN_AMP, im=0.
  - din_rdy=0 on those cycles, so no data is consumed.
  - Each symbol consumes NFFT-NFFT/64 data samples.
- Undefined: no pilots; every DATA subcarrier comes from din.

Decomposition:
- Shared package (global define header): default DW, NFFT, NSYM, TRAIN_AMP, the LFSR seed 9'h1FF, the LFSR tap positions, PILOT_SPACING=64, and state encodings.
- The receiver channel-estimate reference uses the same LFSR constants.
- One sub-module: tx_train_lfsr (9-bit LFSR with load and enable, outputs the current sign bit).

Test Plan:
- Reset then start, din_vld=1 always, NSYM=7, GAP=10:
  - 512 training samples with dout_train=1; the first value is -1024 if LFSR[0]=1 for seed 1FF, i.e. re=12'hC00, im=0.
  - 10 idle cycles, then 7x512 samples equal to the input; 10 idle cycles between symbols.
  - done asserts only with sample 3583 of the data.
- Ramp input din_re = index mod 2048 with din_vld toggling 1/0 every cycle:
  - dout follows the ramp with no skips or duplicates.
  - dout_sos appears 7 times; total valid data samples = 3584.
- start re-pulsed at training sample 100 -> ignored; frame length unchanged; busy stays 1.
- rst asserted at data sample 1000 -> next cycle all outputs 0, state IDLE; a new start produces a full frame from training sample 0 with LFSR reseeded.
- Training sequence check: the 512 training re values match the bench's LFSR model (x^9+x^5+1, seed 1FF) bit-exact; im always 0.
- With TX_FRAME_PILOT_EN defined:
  - data samples at sc 0, 64, ..., 448 equal re=1024, im=0, and din_rdy is low on those cycles.
  - Input consumed per frame = 7x504 = 3528.
